gb_irq_ctrl: RTL and testbench

Parametrised interrupt controller for the Game Boy core, replacing the fixed 5-source IE/IF logic in the top level. It owns the IE ($FFFF) and IF ($FF0F) registers and synchronises and edge-detects raw event sources. It drives the active-low CPU interrupt request and supplies the vector byte during the CPU interrupt-acknowledge cycle. The vector is latched for the whole acknowledge and the serviced flag is cleared when the acknowledge ends.

---
 rtl/gb_irq_pkg.sv | 27 ++
 rtl/gb_irq_ctrl_if.sv | 28 ++
 rtl/gb_irq_edge.sv | 42 ++++
 rtl/gb_irq_ctrl.sv | 102 ++++++++++
 tb/tb_gb_irq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gb_irq_pkg.sv
// rtl/gb_irq_pkg.sv - DMG interrupt constants and priority helper
package gb_irq_pkg;

    localparam int         DMG_NUM_IRQ    = 5;
    localparam logic [7:0] DMG_VEC_BASE   = 8'h40;
    localparam logic [7:0] DMG_VEC_STRIDE = 8'd8;
    localparam logic [7:0] DMG_IDLE_VEC   = 8'h55;

    typedef enum logic [2:0] {
        SRC_VBLANK = 3'd0,
        SRC_LCDC   = 3'd1,
        SRC_TIMER  = 3'd2,
        SRC_SERIAL = 3'd3,
        SRC_JOYPAD = 3'd4
    } dmg_src_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/gb_irq_ctrl_if.sv
// rtl/gb_irq_ctrl_if.sv - CPU register, event and acknowledge bundle for gb_irq_ctrl
interface gb_irq_ctrl_if
    import gb_irq_pkg::*;
#(
    parameter int NUM_IRQ = DMG_NUM_IRQ
);
    logic [NUM_IRQ-1:0] src;
    logic               cpu_sel_ie;
    logic               cpu_sel_if;
    logic               cpu_wr;
    logic [7:0]         cpu_di;
    logic [7:0]         ie_do;
    logic [7:0]         if_do;
    logic               irq_ack;
    logic               irq_n;
    logic [7:0]         irq_vec;
    logic [2:0]         irq_id;

    modport master (
        output src, cpu_sel_ie, cpu_sel_if, cpu_wr, cpu_di, irq_ack,
        input  ie_do, if_do, irq_n, irq_vec, irq_id
    );

    modport slave (
        input  src, cpu_sel_ie, cpu_sel_if, cpu_wr, cpu_di, irq_ack,
        output ie_do, if_do, irq_n, irq_vec, irq_id
    );
endinterface

// File: rtl/gb_irq_edge.sv
// rtl/gb_irq_edge.sv - synchroniser plus single-polarity edge detector for one source
module gb_irq_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic POL         = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic evt
);
    logic synced;
    logic hist;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign synced = din;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sr;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sr <= '0;
                end else begin
                    sr[0] <= din;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sr[k] <= sr[k-1];
                    end
                end
            end

            assign synced = sr[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hist <= 1'b0;
        else          hist <= synced;
    end

    assign evt = (synced != hist) && (synced == POL);

endmodule

// File: rtl/gb_irq_ctrl.sv
// rtl/gb_irq_ctrl.sv - IE/IF registers, source capture, priority and acknowledge vector latch
module gb_irq_ctrl
    import gb_irq_pkg::*;
#(
    parameter int                 NUM_IRQ     = DMG_NUM_IRQ,
    parameter logic [7:0]         VEC_BASE    = DMG_VEC_BASE,
    parameter logic [7:0]         VEC_STRIDE  = DMG_VEC_STRIDE,
    parameter logic [7:0]         IDLE_VEC    = DMG_IDLE_VEC,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = NUM_IRQ'(5'b10001),
    parameter logic [NUM_IRQ-1:0] EDGE_POL    = NUM_IRQ'(5'b00001),
    parameter int                 SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    gb_irq_ctrl_if.slave  bus
);
    logic [NUM_IRQ-1:0] ie_r;
    logic [NUM_IRQ-1:0] if_r;
    logic [NUM_IRQ-1:0] if_nxt;
    logic [NUM_IRQ-1:0] evt;
    logic [NUM_IRQ-1:0] pend;
    logic               ack_d;
    logic               ack_rise;
    logic               ack_fall;
    logic [7:0]         lat_vec;
    logic [2:0]         lat_id;
    logic [7:0]         live_vec;
    logic [2:0]         live_id;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            if (EDGE_MASK[gi]) begin : g_edge
                gb_irq_edge #(
                    .SYNC_STAGES (SYNC_STAGES),
                    .POL         (EDGE_POL[gi])
                ) u_edge (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .din     (bus.src[gi]),
                    .evt     (evt[gi])
                );
            end else begin : g_pulse
                assign evt[gi] = bus.src[gi];
            end
        end
    endgenerate

    assign pend     = ie_r & if_r;
    assign live_id  = lowest_set(8'(pend));
    assign live_vec = (|pend) ? (VEC_BASE + 8'(live_id) * VEC_STRIDE) : IDLE_VEC;

    assign ack_rise = bus.irq_ack && !ack_d;
    assign ack_fall = !bus.irq_ack && ack_d;

    // Ordering sets precedence: ack clear, then CPU write, then events OR'd on top.
    always_comb begin
        if_nxt = if_r;
        if (ack_fall && (lat_vec != IDLE_VEC)) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (3'(i) == lat_id) if_nxt[i] = 1'b0;
            end
        end
        if (bus.cpu_sel_if && bus.cpu_wr) begin
            if_nxt = bus.cpu_di[NUM_IRQ-1:0];
        end
        if_nxt = if_nxt | evt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_r    <= '0;
            if_r    <= '0;
            ack_d   <= 1'b0;
            lat_vec <= IDLE_VEC;
            lat_id  <= 3'd0;
        end else begin
            if (bus.cpu_sel_ie && bus.cpu_wr) begin
                ie_r <= bus.cpu_di[NUM_IRQ-1:0];
            end
            if_r  <= if_nxt;
            ack_d <= bus.irq_ack;
            if (ack_rise) begin
                lat_vec <= live_vec;
                lat_id  <= live_id;
            end
        end
    end

    always_comb begin
        bus.ie_do                = 8'h00;
        bus.ie_do[NUM_IRQ-1:0]   = ie_r;
        bus.if_do                = 8'hFF;
        bus.if_do[NUM_IRQ-1:0]   = if_r;
    end

    // The first acknowledge cycle still shows the live vector; the latch takes it at that edge.
    assign bus.irq_vec = (bus.irq_ack && ack_d) ? lat_vec : live_vec;
    assign bus.irq_n   = ~|pend;
    assign bus.irq_id  = live_id;

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// tb/tb_gb_irq_ctrl.sv - scoreboard bench for gb_irq_ctrl with a cycle-level reference model
module tb_gb_irq_ctrl;

    localparam int         N     = 5;
    localparam int         S     = 2;
    localparam logic [7:0] VB    = 8'h40;
    localparam logic [7:0] VS    = 8'd8;
    localparam logic [7:0] IDLE  = 8'h55;
    localparam logic [4:0] EMASK = 5'b10001;
    localparam logic [4:0] EPOL  = 5'b00001;

    logic clk;
    logic reset_n;

    gb_irq_ctrl_if #(.NUM_IRQ(N)) bus ();

    gb_irq_ctrl #(
        .NUM_IRQ     (N),
        .VEC_BASE    (VB),
        .VEC_STRIDE  (VS),
        .IDLE_VEC    (IDLE),
        .EDGE_MASK   (EMASK),
        .EDGE_POL    (EPOL),
        .SYNC_STAGES (S)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         fld;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [4:0] m_ie, m_if;
    logic       m_ackd;
    logic [7:0] m_lvec;
    int         m_lid;
    logic [4:0] m_hist[$];

    function automatic logic [7:0] dut_field(input int f);
        case (f)
            0:       return {7'b0, bus.irq_n};
            1:       return bus.irq_vec;
            2:       return {5'b0, bus.irq_id};
            3:       return bus.ie_do;
            default: return bus.if_do;
        endcase
    endfunction

    task automatic model_reset();
        m_ie   = '0;
        m_if   = '0;
        m_ackd = 1'b0;
        m_lvec = IDLE;
        m_lid  = 0;
        m_hist = {};
        for (int i = 0; i < S + 1; i++) m_hist.push_back(5'b0);
    endtask

    task automatic expect_now(input string name, input int fld, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.fld  = fld;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic check_direct(input string name, input logic [7:0] act, input logic [7:0] val);
        n_checks++;
        if (act !== val) begin
            n_errors++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, val);
        end
    endtask

    task automatic cyc(input bit rn, input logic [4:0] s, input bit sie, input bit sif,
                       input bit wr, input logic [7:0] di, input bit ack);
        logic [4:0] pend, ev, synced, old, nxt;
        int         id;
        bit         found;
        logic [7:0] live;
        @(posedge clk);
        #1;
        reset_n        = rn;
        bus.src        = s;
        bus.cpu_sel_ie = sie;
        bus.cpu_sel_if = sif;
        bus.cpu_wr     = wr;
        bus.cpu_di     = di;
        bus.irq_ack    = ack;
        if (!rn) model_reset();

        pend  = m_ie & m_if;
        id    = 0;
        found = 0;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && !found) begin
                id    = i;
                found = 1;
            end
        end
        live = found ? 8'(VB + id * VS) : IDLE;
        expect_now("irq_n",   0, {7'b0, (pend == 0)});
        expect_now("irq_vec", 1, (ack && m_ackd) ? m_lvec : live);
        expect_now("irq_id",  2, 8'(id));
        expect_now("ie_do",   3, {3'b000, m_ie});
        expect_now("if_do",   4, {3'b111, m_if});

        if (rn) begin
            m_hist.push_back(s);
            synced = m_hist[1];
            old    = m_hist[0];
            void'(m_hist.pop_front());
            for (int i = 0; i < N; i++) begin
                ev[i] = EMASK[i] ? ((synced[i] != old[i]) && (synced[i] == EPOL[i])) : s[i];
            end
            nxt = m_if;
            if (!ack && m_ackd && m_lvec != IDLE) nxt[m_lid] = 1'b0;
            if (sif && wr) nxt = di[4:0];
            m_if = nxt | ev;
            if (sie && wr) m_ie = di[4:0];
            if (ack && !m_ackd) begin
                m_lvec = live;
                m_lid  = id;
            end
            m_ackd = ack;
        end
    endtask

    task automatic idle(input logic [4:0] s, input bit ack);
        cyc(1, s, 0, 0, 0, 8'h00, ack);
    endtask

    task automatic wr_if(input logic [7:0] v);
        cyc(1, 5'b0, 0, 1, 1, v, 0);
    endtask

    initial begin : watchdog
        #200000;
        n_errors++;
        $display("FAIL timeout at %0t: simulation did not finish", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = dut_field(e.fld);
                n_checks++;
                if (act !== e.val) begin
                    n_errors++;
                    $display("FAIL %s at %0t: got %02h expected %02h", e.name, $time, act, e.val);
                end
            end
        end
    end

    initial begin : driver
        logic [4:0] lvl;
        bit         ack;
        reset_n        = 1'b0;
        bus.src        = '0;
        bus.cpu_sel_ie = 1'b0;
        bus.cpu_sel_if = 1'b0;
        bus.cpu_wr     = 1'b0;
        bus.cpu_di     = 8'h00;
        bus.irq_ack    = 1'b0;
        model_reset();

        cyc(0, 5'b0, 0, 0, 0, 8'h00, 0);
        #1;
        check_direct("rst_now_irq_n", {7'b0, bus.irq_n}, 8'h01);
        check_direct("rst_now_vec",   bus.irq_vec,       8'h55);
        check_direct("rst_now_id",    {5'b0, bus.irq_id}, 8'h00);
        check_direct("rst_now_ie",    bus.ie_do,         8'h00);
        check_direct("rst_now_if",    bus.if_do,         8'hE0);
        expect_now("rst_irq_n", 0, 8'h01);
        expect_now("rst_vec",   1, 8'h55);
        expect_now("rst_ie",    3, 8'h00);
        expect_now("rst_if",    4, 8'hE0);
        cyc(0, 5'b0, 0, 0, 0, 8'h00, 0);

        cyc(1, 5'b0, 1, 0, 1, 8'h1F, 0);
        idle(5'b00100, 0);
        idle(5'b0, 0);
        expect_now("pulse_if",  4, 8'hE4);
        expect_now("pulse_irq", 0, 8'h00);
        expect_now("pulse_vec", 1, 8'h50);
        expect_now("pulse_id",  2, 8'h02);
        wr_if(8'h00);

        wr_if(8'h12);
        idle(5'b00000, 1); expect_now("ack_vec1", 1, 8'h48);
        idle(5'b00001, 1); expect_now("ack_vec2", 1, 8'h48);
        idle(5'b00000, 1); expect_now("ack_vec3", 1, 8'h48);
        idle(5'b00000, 0);
        idle(5'b00000, 0);
        expect_now("ackend_if",  4, 8'hF1);
        expect_now("ackend_vec", 1, 8'h40);
        wr_if(8'h00);

        for (int i = 0; i < 4; i++) begin
            idle(5'b10000, 0);
            expect_now("joy_rise", 4, 8'hE0);
        end
        for (int i = 0; i < 3; i++) begin
            idle(5'b00000, 0);
            expect_now("joy_lat", 4, 8'hE0);
        end
        idle(5'b00000, 0);
        expect_now("joy_fall", 4, 8'hF0);
        wr_if(8'h00);
        idle(5'b10000, 0);
        for (int i = 0; i < 3; i++) idle(5'b00000, 0);
        idle(5'b00000, 0);
        expect_now("joy_glitch", 4, 8'hF0);
        wr_if(8'h00);
        for (int i = 0; i < 3; i++) begin
            idle(5'b00000, 0);
            expect_now("joy_once", 4, 8'hE0);
        end

        wr_if(8'h04);
        idle(5'b00000, 1);
        idle(5'b00000, 1);
        idle(5'b00100, 0);
        idle(5'b00000, 0);
        expect_now("coll_ack", 4, 8'hE4);
        cyc(1, 5'b00100, 0, 1, 1, 8'h00, 0);
        idle(5'b00000, 0);
        expect_now("coll_wr", 4, 8'hE4);
        wr_if(8'h00);

        wr_if(8'h01);
        idle(5'b00000, 1);
        idle(5'b00000, 1);
        cyc(0, 5'b0, 0, 0, 0, 8'h00, 1);
        expect_now("mid_irq_n", 0, 8'h01);
        expect_now("mid_vec",   1, 8'h55);
        expect_now("mid_id",    2, 8'h00);
        expect_now("mid_ie",    3, 8'h00);
        expect_now("mid_if",    4, 8'hE0);
        idle(5'b00000, 0);
        idle(5'b00000, 0);
        expect_now("mid_noclr", 4, 8'hE0);

        lvl = '0;
        ack = 0;
        for (int n = 0; n < 800; n++) begin
            logic [4:0] s;
            if ($urandom_range(0, 7) == 0) lvl[0] = ~lvl[0];
            if ($urandom_range(0, 7) == 0) lvl[4] = ~lvl[4];
            s = lvl;
            for (int b = 1; b < 4; b++) s[b] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) == 0) ack = ~ack;
            cyc(($urandom_range(0, 199) != 0), s, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                8'($urandom), ack);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain at %0t: %0d expectations never checked", $time, exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
